i2c_cfg_sequencer: RTL and testbench

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

---
 rtl/i2c_cpu_pkg.sv | 32 +++
 rtl/i2c_cfg_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cpu_pkg.sv
// Shared definitions for the I2C core configuration sequencer: register map,
// AXI response codes and the sequencer state encoding.
package i2c_cpu_pkg;

  localparam logic [3:0] REG_CONTROL = 4'h0;
  localparam logic [3:0] REG_ADDRESS = 4'h8;
  localparam logic [3:0] REG_CKCOUNT = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_GAP,
    ST_RADDR,
    ST_RDATA
  } state_t;

  // Register targeted by write number 0..2 of a sequence.
  function automatic logic [3:0] wr_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    wr_offset = REG_CKCOUNT;
      2'd1:    wr_offset = REG_ADDRESS;
      default: wr_offset = REG_CONTROL;
    endcase
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer.sv
// Writes CKCOUNT, ADDRESS, CONTROL over AXI-Lite, then polls CONTROL until idle.
// Optional poll timeout enabled by defining I2CSEQ_TIMEOUT_EN.
module i2c_cfg_sequencer
  import i2c_cpu_pkg::*;
#(
  parameter int BUSY_BIT  = 31,
  parameter int POLL_GAP  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        i_start,
  input  logic [31:0] i_ckcount,
  input  logic [31:0] i_address,
  input  logic [31:0] i_control,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_status,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [3:0]  M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [3:0]  M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic [31:0] ck_q, ck_d, ad_q, ad_d, ct_q, ct_d;
  logic [1:0]  widx_q, widx_d;
  logic [15:0] gap_q, gap_d;
  logic        awv_d, wv_d, bready_d, arv_d, rready_d;
  logic [3:0]  awaddr_d;
  logic [31:0] wdata_d, status_d;
  logic        done_d, err_d;
`ifdef I2CSEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_q, to_d;
`endif

  assign o_busy       = (state_q != ST_IDLE);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign M_AXI_ARADDR = REG_CONTROL;

  always_comb begin
    // NOTE: every value is defaulted before the case so no branch can infer a latch.
    state_d  = state_q;
    ck_d     = ck_q;
    ad_d     = ad_q;
    ct_d     = ct_q;
    widx_d   = widx_q;
    gap_d    = gap_q;
    awv_d    = M_AXI_AWVALID;
    wv_d     = M_AXI_WVALID;
    bready_d = M_AXI_BREADY;
    arv_d    = M_AXI_ARVALID;
    rready_d = M_AXI_RREADY;
    awaddr_d = M_AXI_AWADDR;
    wdata_d  = M_AXI_WDATA;
    status_d = o_status;
    done_d   = 1'b0;
    err_d    = o_err;
`ifdef I2CSEQ_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A start coinciding with the completion pulse is dropped.
        if (i_start && !o_done) begin
          ck_d     = i_ckcount;
          ad_d     = i_address;
          ct_d     = i_control;
          err_d    = 1'b0;
          widx_d   = 2'd0;
          awv_d    = 1'b1;
          wv_d     = 1'b1;
          awaddr_d = wr_offset(2'd0);
          wdata_d  = i_ckcount;
          state_d  = ST_WADDR;
        end
      end
      ST_WADDR: begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) awv_d = 1'b0;
        if (M_AXI_WVALID && M_AXI_WREADY)   wv_d  = 1'b0;
        if (!awv_d && !wv_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (widx_q == 2'd2) begin
            gap_d   = '0;
            state_d = ST_GAP;
`ifdef I2CSEQ_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            widx_d   = widx_q + 2'd1;
            awv_d    = 1'b1;
            wv_d     = 1'b1;
            awaddr_d = wr_offset(widx_q + 2'd1);
            wdata_d  = (widx_q == 2'd0) ? ad_q : ct_q;
            state_d  = ST_WADDR;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          arv_d   = 1'b1;
          state_d = ST_RADDR;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_RADDR: begin
        if (M_AXI_ARREADY) begin
          arv_d    = 1'b0;
          rready_d = 1'b1;
          state_d  = ST_RDATA;
`ifdef I2CSEQ_TIMEOUT_EN
          to_d     = to_q + TIMEOUT_W'(1);
`endif
        end
      end
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          status_d = M_AXI_RDATA;
          if (M_AXI_RRESP != RESP_OKAY) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (!M_AXI_RDATA[BUSY_BIT]) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
`ifdef I2CSEQ_TIMEOUT_EN
            if (&to_q) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
`else
            gap_d   = '0;
            state_d = ST_GAP;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q       <= ST_IDLE;
      ck_q          <= '0;
      ad_q          <= '0;
      ct_q          <= '0;
      widx_q        <= '0;
      gap_q         <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      o_status      <= '0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
`ifdef I2CSEQ_TIMEOUT_EN
      to_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ck_q          <= ck_d;
      ad_q          <= ad_d;
      ct_q          <= ct_d;
      widx_q        <= widx_d;
      gap_q         <= gap_d;
      M_AXI_AWVALID <= awv_d;
      M_AXI_WVALID  <= wv_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arv_d;
      M_AXI_RREADY  <= rready_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_WDATA   <= wdata_d;
      o_status      <= status_d;
      o_done        <= done_d;
      o_err         <= err_d;
`ifdef I2CSEQ_TIMEOUT_EN
      to_q          <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: scripted AXI-Lite slave, transaction-level model
// and a per-cycle protocol monitor. Covers I2CSEQ_TIMEOUT_EN when defined.
module tb_i2c_cfg_sequencer;

`ifdef I2CSEQ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif
  localparam int POLL_GAP = 8;
  localparam int TO_MAX   = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_ckcount = '0, i_address = '0, i_control = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_status;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(.BUSY_BIT(31), .POLL_GAP(POLL_GAP), .TIMEOUT_W(TW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .i_start(i_start),
    .i_ckcount(i_ckcount), .i_address(i_address), .i_control(i_control),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_status(o_status),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave configuration and transaction log
  int          aw_delay = 0, w_delay = 0;
  logic [1:0]  bresp_tab [3];
  int          busy_reads = 0;
  logic [31:0] final_rd = '0;
  bit          b_block = 0;
  logic [3:0]  aw_log[$];
  logic [31:0] w_log[$];
  int          ar_cyc[$];
  int          b_done = 0, r_done = 0, aw_cnt = 0, w_cnt = 0;
  bit          b_hs = 0, r_hs = 0;
  int          cyc = 0;
  int          done_cnt = 0, aw_hi = 0, w_hi = 0;

  initial forever @(posedge clk) cyc++;

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_cyc.delete();
    b_done = 0; r_done = 0; done_cnt = 0; aw_hi = 0; w_hi = 0;
  endtask

  // AXI-Lite slave: decisions made at negedge, handshakes complete at the next posedge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        b_hs = 0; r_hs = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      if (!bvalid && !b_block && aw_log.size() > b_done && w_log.size() > b_done) begin
        bvalid = 1; bresp = bresp_tab[b_done];
      end
      if (bvalid && bready) begin b_hs = 1; b_done++; end
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (!rvalid && ar_cyc.size() > r_done) begin
        rvalid = 1; rresp = 2'b00;
        rdata = (r_done < busy_reads) ? (32'h8000_0000 | 32'(r_done)) : final_rd;
      end
      if (rvalid && rready) begin r_hs = 1; r_done++; end
      if (awvalid) begin
        awready = (aw_cnt >= aw_delay);
        if (awready) begin aw_log.push_back(awaddr); aw_cnt = 0; end else aw_cnt++;
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        wready = (w_cnt >= w_delay);
        if (wready) begin w_log.push_back(wdata); w_cnt = 0; end else w_cnt++;
      end else begin wready = 0; w_cnt = 0; end
      arready = arvalid;
      if (arvalid) ar_cyc.push_back(cyc);
    end
  end

  // Per-cycle protocol / handshake-rule monitor
  logic       p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic       p_busy = 0, p_acc = 0, p_done = 0;
  logic [3:0] p_awaddr = '0;
  logic [31:0] p_wdata = '0;
  initial forever begin
    @(negedge clk); #1;
    if (rst) begin
      p_awv = 0; p_wv = 0; p_arv = 0; p_busy = 0; p_acc = 0; p_done = 0;
      continue;
    end
    check("const_outs", {22'd0, awprot, arprot, wstrb}, 32'h0000_000F);
    if (p_awv && !p_awr) begin
      check("awvalid_held", awvalid, 1); check("awaddr_stable", awaddr, p_awaddr);
    end
    if (p_wv && !p_wr) begin
      check("wvalid_held", wvalid, 1); check("wdata_stable", wdata, p_wdata);
    end
    if (p_arv && !p_arr) check("arvalid_held", arvalid, 1);
    if (!p_busy) check("start_accept", o_busy, p_acc);
    else if (!o_busy) check("busy_end_done", o_done, 1);
    if (o_done) check("done_idle", o_busy, 0);
    if (p_done) check("done_one_cycle", o_done, 0);
    if (o_done) done_cnt++;
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata;
    p_arv = arvalid; p_arr = arready;
    p_acc = i_start && !o_busy && !o_done;
    p_busy = o_busy; p_done = o_done;
  end

  logic [31:0] status_m = '0;

  // One complete sequence; expectations derived from the slave script.
  task automatic run_seq(input logic [31:0] ck, input logic [31:0] ad, input logic [31:0] ct,
                         input bit start_at_done);
    logic [3:0]  exp_a [3];
    logic [31:0] exp_d [3];
    int nw, nr, n;
    bit werr, terr;
    exp_a = '{4'hC, 4'h8, 4'h0};
    exp_d = '{ck, ad, ct};
    nw = 3; werr = 0; terr = 0;
    for (int i = 0; i < 3; i++)
      if (!werr && bresp_tab[i] != 2'b00) begin nw = i + 1; werr = 1; end
    nr = werr ? 0 : busy_reads + 1;
`ifdef I2CSEQ_TIMEOUT_EN
    if (!werr && busy_reads >= TO_MAX) begin nr = TO_MAX; terr = 1; end
`endif
    if (nr > 0) status_m = (nr - 1 < busy_reads) ? (32'h8000_0000 | 32'(nr - 1)) : final_rd;

    @(negedge clk);
    clear_logs();
    i_ckcount = ck; i_address = ad; i_control = ct; i_start = 1;
    @(negedge clk);
    i_start = 0;
    check("err_cleared_on_start", o_err, 0);
    i_ckcount = 32'hDEAD_BEEF; i_address = 32'hDEAD_BEEF; i_control = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    n = 0;
    while (!o_done && n < 3000) begin @(negedge clk); n++; end
    check("seq_done_in_time", o_done, 1);
    if (start_at_done) begin
      i_start = 1;
      @(negedge clk);
      i_start = 0;
    end
    repeat (20) @(negedge clk);
    check("write_count", aw_log.size(), nw);
    check("wdata_count", w_log.size(), nw);
    for (int i = 0; i < nw && i < aw_log.size() && i < w_log.size(); i++) begin
      check("write_addr", aw_log[i], exp_a[i]);
      check("write_data", w_log[i], exp_d[i]);
    end
    check("read_count", ar_cyc.size(), nr);
    for (int i = 1; i < ar_cyc.size(); i++)
      check("read_gap_ok", 32'(ar_cyc[i] - ar_cyc[i-1] >= POLL_GAP), 1);
    check("done_pulses", done_cnt, 1);
    check("err_flag", o_err, werr || terr);
    check("status", o_status, status_m);
    check("busy_after", o_busy, 0);
  endtask

  task automatic cfg(input int awd, input logic [1:0] br1, input int busy_n, input logic [31:0] fin);
    aw_delay = awd; w_delay = 0;
    bresp_tab = '{2'b00, br1, 2'b00};
    busy_reads = busy_n; final_rd = fin;
  endtask

  initial begin
    int n;
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset_outs", {o_busy, o_done, o_err, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("reset_status", o_status, 0);
    rst = 0;

    // Basic sequence, always-ready slave, first read already idle
    cfg(0, 2'b00, 0, 32'h0008_0000);
    run_seq(32'd200, 32'h50, 32'h0008_0000, 0);
    check("pin_first_addr", aw_log.size() > 0 ? aw_log[0] : 4'hX, 4'hC);
    check("pin_first_data", w_log.size() > 0 ? w_log[0] : 'x, 32'd200);
    check("pin_last_addr", aw_log.size() > 2 ? aw_log[2] : 4'hX, 4'h0);
    check("pin_status", o_status, 32'h0008_0000);

    // AWREADY stalls 5 cycles per write, WREADY immediate
    cfg(5, 2'b00, 0, 32'h0000_0001);
    run_seq(32'd1000, 32'h21, 32'h0001_0000, 0);
    check("pin_aw_cycles", aw_hi, 32'd18);
    check("pin_w_cycles", w_hi, 32'd3);

    // Busy for three reads, then clear; start at the done cycle ignored
    cfg(0, 2'b00, 3, 32'h0000_1234);
    run_seq(32'd400, 32'h3C, 32'h0008_0001, 1);
    check("pin_reads", ar_cyc.size(), 32'd4);
    check("pin_status_final", o_status, 32'h0000_1234);

    // SLVERR on the second write
    cfg(0, 2'b10, 0, 32'h0);
    run_seq(32'd7, 32'h11, 32'h22, 0);
    check("pin_err_set", o_err, 1);

    // Recovery after error
    cfg(0, 2'b00, 1, 32'h0000_0055);
    run_seq(32'd9, 32'h12, 32'h0008_0000, 0);

    // Reset while waiting for the write response
    cfg(0, 2'b00, 0, 32'h0);
    b_block = 1;
    @(negedge clk);
    clear_logs();
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    check("reached_wresp", bready, 1);
    rst = 1;
    #1;
    check("rst_async_outs", {o_busy, o_done, o_err, awvalid, wvalid, bready, arvalid, rready}, 0);
    @(posedge clk); #1;
    check("rst_outs", {o_busy, o_done, o_err, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_status", o_status, 0);
    check("rst_addr_data", {awaddr, wdata[27:0]}, 0);
    status_m = '0;
    @(negedge clk);
    rst = 0;
    b_block = 0;

    cfg(0, 2'b00, 0, 32'h0000_00A5);
    run_seq(32'd200, 32'h50, 32'h0008_0000, 0);

`ifdef I2CSEQ_TIMEOUT_EN
    cfg(0, 2'b00, 1000, 32'h0);
    run_seq(32'd1, 32'h2, 32'h3, 0);
    check("pin_timeout_reads", ar_cyc.size(), 32'd15);
    check("pin_timeout_err", o_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
